// File: rtl/vga_sprite_reader.sv
// Double-buffered sprite line reader: fetches the next scanline's 32 sprite words from RAM
// while the current line is drawn. Optional macro SPRITE_MIRROR_EN adds the mirror_x input.
module vga_sprite_reader #(
   parameter logic [15:0] TRANSPARENT_KEY = 16'hF81F,
   parameter int          WORDS_PER_LINE  = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        line_start,
   input  logic [9:0]  draw_y,
   input  logic [9:0]  draw_x,
   input  logic [9:0]  sprite_x,
   input  logic [9:0]  sprite_y,
   input  logic        frame_sel,
   input  logic        enable,
`ifdef SPRITE_MIRROR_EN
   input  logic        mirror_x,
`endif
   output logic [10:0] mem_address,
   output logic        mem_chipselect,
   input  logic [15:0] mem_readdata,
   output logic [15:0] pix_color,
   output logic        pix_valid,
   output logic        busy,
   output logic        overrun,
   input  logic        overrun_clr
);

   localparam int              COL_W    = $clog2(WORDS_PER_LINE);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(WORDS_PER_LINE - 1);
   localparam logic [9:0]       LINE_LEN = 10'(WORDS_PER_LINE);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t             state, next_state;
   logic [COL_W-1:0]   col;
   logic [COL_W-1:0]   fetch_row;
   logic               fetch_frame;
   logic [COL_W-1:0]   addr_col;
   logic [9:0]         next_row;
   logic               start_ok;
   logic               abort;

   logic               front_sel;
   logic               front_hit, back_hit;
   logic [9:0]         front_x, back_x;

   logic               cap_valid;
   logic               cap_sel;
   logic [COL_W-1:0]   cap_col;
   logic [15:0]        line_buf [2][WORDS_PER_LINE];

   logic [9:0]         pix_col;
   logic [15:0]        front_word;
   logic               opaque;

   assign next_row = draw_y + 10'd1 - sprite_y;
   assign start_ok = enable && (next_row < LINE_LEN);
   assign abort    = line_start && (state != IDLE);
   assign busy     = (state != IDLE);

`ifdef SPRITE_MIRROR_EN
   logic fetch_mirror;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        fetch_mirror <= 1'b0;
      else if (line_start) fetch_mirror <= mirror_x;
   end

   // The line is stored in fetch order, so reversing the RAM column mirrors the drawn sprite.
   assign addr_col = fetch_mirror ? ~col : col;
`else
   assign addr_col = col;
`endif

   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // NOTE: every output of this block gets a default first, so no latch can be inferred.
   always_comb begin
      next_state     = state;
      mem_chipselect = 1'b0;
      mem_address    = '0;
      unique case (state)
         IDLE: begin
            if (line_start && start_ok) next_state = FETCH;
         end
         FETCH: begin
            mem_chipselect = 1'b1;
            mem_address    = {fetch_frame, fetch_row, addr_col};
            if (line_start)             next_state = start_ok ? FETCH : IDLE;
            else if (col == LAST_COL)   next_state = DRAIN;
         end
         DRAIN: begin
            next_state = (line_start && start_ok) ? FETCH : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Line bookkeeping: a new line swaps the buffers; an unfinished back buffer carries hit=0 forward.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col         <= '0;
         fetch_row   <= '0;
         fetch_frame <= 1'b0;
         front_sel   <= 1'b0;
         front_hit   <= 1'b0;
         back_hit    <= 1'b0;
         front_x     <= '0;
         back_x      <= '0;
      end else if (line_start) begin
         col         <= '0;
         fetch_row   <= next_row[COL_W-1:0];
         fetch_frame <= frame_sel;
         front_sel   <= ~front_sel;
         front_hit   <= back_hit;
         back_hit    <= 1'b0;
         front_x     <= back_x;
         back_x      <= sprite_x;
      end else begin
         if (state == FETCH) col      <= col + 1'b1;
         if (state == DRAIN) back_hit <= 1'b1;
      end
   end

   // Read data arrives one cycle after its address; remember where it belongs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cap_valid <= 1'b0;
         cap_sel   <= 1'b0;
         cap_col   <= '0;
      end else begin
         cap_valid <= (state == FETCH) && !line_start;
         cap_sel   <= ~front_sel;
         cap_col   <= col;
      end
   end

   // NOTE: buffer storage is deliberately not reset; hit flags gate every read of stale data.
   always_ff @(posedge clk) begin
      if (cap_valid) line_buf[cap_sel][cap_col] <= mem_readdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)         overrun <= 1'b0;
      else if (abort)       overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
   end

   assign pix_col    = draw_x - front_x;
   assign front_word = line_buf[front_sel][pix_col[COL_W-1:0]];
   assign opaque     = front_hit && (pix_col < LINE_LEN) &&
                       (front_word != TRANSPARENT_KEY) && enable;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_valid <= 1'b0;
         pix_color <= '0;
      end else begin
         pix_valid <= opaque;
         pix_color <= opaque ? front_word : 16'h0000;
      end
   end

endmodule

// File: tb/tb_vga_sprite_reader.sv
// Self-checking bench for vga_sprite_reader: directed scenarios plus randomized lines against
// a line-level model of the sprite RAM, buffer swap and 33-cycle fetch rule.
module tb_vga_sprite_reader;

   localparam logic [15:0] KEY = 16'hF81F;
`ifdef SPRITE_MIRROR_EN
   localparam bit MIRROR_ON = 1'b1;
`else
   localparam bit MIRROR_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        line_start;
   logic [9:0]  draw_y, draw_x, sprite_x, sprite_y;
   logic        frame_sel, enable, mirror_x;
   logic [10:0] mem_address;
   logic        mem_chipselect;
   logic [15:0] mem_readdata;
   logic [15:0] pix_color;
   logic        pix_valid, busy, overrun, overrun_clr;

   logic [15:0] ram [2048];

   int total = 0;
   int bad   = 0;

   // line-level reference model
   bit          m_front_hit, m_back_hit, m_fetching, m_overrun, m_mir;
   int          m_front_x, m_back_x, m_row, m_frame, since;
   logic [15:0] m_front_w [32];
   logic [15:0] m_back_w  [32];

   vga_sprite_reader dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .line_start     (line_start),
      .draw_y         (draw_y),
      .draw_x         (draw_x),
      .sprite_x       (sprite_x),
      .sprite_y       (sprite_y),
      .frame_sel      (frame_sel),
      .enable         (enable),
`ifdef SPRITE_MIRROR_EN
      .mirror_x       (mirror_x),
`endif
      .mem_address    (mem_address),
      .mem_chipselect (mem_chipselect),
      .mem_readdata   (mem_readdata),
      .pix_color      (pix_color),
      .pix_valid      (pix_valid),
      .busy           (busy),
      .overrun        (overrun),
      .overrun_clr    (overrun_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mem_readdata <= ram[mem_address];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int wrap(input int v);
      return ((v % 1024) + 1024) % 1024;
   endfunction

   task automatic model_reset();
      m_front_hit = 0; m_back_hit = 0; m_fetching = 0; m_overrun = 0; m_mir = 0;
      m_front_x = 0; m_back_x = 0; m_row = 0; m_frame = 0; since = 0;
   endtask

   task automatic tick();
      bit clr;
      clr = overrun_clr;
      @(posedge clk); #1;
      since++;
      if (clr) m_overrun = 0;
      if (m_fetching && since == 33) begin
         m_back_hit = 1;
         m_fetching = 0;
      end
   endtask

   task automatic ls(input int y, input int sx, input int sy, input int fr, input bit mir, input bit clr);
      bit en;
      draw_y = 10'(y); sprite_x = 10'(sx); sprite_y = 10'(sy);
      frame_sel = fr[0]; mirror_x = mir; overrun_clr = clr; line_start = 1'b1;
      en = enable;
      @(posedge clk); #1;
      line_start = 1'b0; overrun_clr = 1'b0;
      if (m_fetching)  m_overrun = 1;
      else if (clr)    m_overrun = 0;
      m_front_hit = m_back_hit; m_front_x = m_back_x; m_front_w = m_back_w;
      m_back_hit = 0; m_back_x = sx;
      m_row = wrap(y + 1 - sy); m_frame = fr; m_mir = mir && mirror_x && MIRROR_ON;
      m_fetching = en && (m_row < 32);
      if (m_fetching)
         for (int c = 0; c < 32; c++)
            m_back_w[c] = ram[m_frame * 1024 + m_row * 32 + (m_mir ? 31 - c : c)];
      since = 0;
   endtask

   task automatic check_bus(input string tag);
      bit exp_cs;
      int exp_addr;
      exp_cs   = m_fetching && since < 32;
      exp_addr = exp_cs ? m_frame * 1024 + m_row * 32 + (m_mir ? 31 - since : since) : 0;
      check({tag, "_cs"},   32'(mem_chipselect), 32'(exp_cs));
      check({tag, "_addr"}, 32'(mem_address),    32'(exp_addr));
      check({tag, "_busy"}, 32'(busy),           32'(m_fetching));
   endtask

   task automatic pix_at(input int x, input string tag);
      int col;
      bit ev;
      logic [15:0] ec;
      draw_x = 10'(x);
      col = wrap(x - m_front_x);
      ev = 0; ec = 16'h0;
      if (m_front_hit && col < 32 && enable && m_front_w[col] != KEY) begin
         ev = 1; ec = m_front_w[col];
      end
      tick();
      check({tag, "_valid"}, 32'(pix_valid), 32'(ev));
      check({tag, "_color"}, 32'(pix_color), 32'(ec));
   endtask

   task automatic pix_expect(input int x, input bit ev, input logic [15:0] ec, input string tag);
      draw_x = 10'(x);
      tick();
      check({tag, "_valid"}, 32'(pix_valid), 32'(ev));
      check({tag, "_color"}, 32'(pix_color), 32'(ec));
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) begin
         ram[i] = 16'($urandom);
         if ($urandom_range(0, 15) == 0) ram[i] = KEY;
         if (ram[i] == KEY && $urandom_range(0, 1) == 0) ram[i] = 16'h1234;
      end
      for (int k = 0; k < 32; k++) ram[11'h400 + k] = 16'h0100 + 16'(k);
      ram[11'h405] = KEY;

      reset_n = 1'b0; line_start = 1'b0; draw_y = '0; draw_x = '0;
      sprite_x = '0; sprite_y = '0; frame_sel = 1'b0; enable = 1'b1;
      mirror_x = 1'b0; overrun_clr = 1'b0;
      model_reset();
      tick(); tick();
      check("rst_busy",  32'(busy),           32'd0);
      check("rst_cs",    32'(mem_chipselect), 32'd0);
      check("rst_addr",  32'(mem_address),    32'd0);
      check("rst_valid", 32'(pix_valid),      32'd0);
      check("rst_color", 32'(pix_color),      32'd0);
      check("rst_ovr",   32'(overrun),        32'd0);
      reset_n = 1'b1;
      tick();

      // fetch of frame 1 row 0: addresses 0x400..0x41F, busy drops 33 cycles after line_start
      ls(49, 100, 50, 1, 0, 0);
      for (int k = 0; k < 32; k++) begin
         check("f38_cs",   32'(mem_chipselect), 32'd1);
         check("f38_addr", 32'(mem_address),    32'h400 + 32'(k));
         check("f38_busy", 32'(busy),           32'd1);
         tick();
      end
      check("f38_drain_busy", 32'(busy),           32'd1);
      check("f38_drain_cs",   32'(mem_chipselect), 32'd0);
      tick();
      check("f38_done_busy",  32'(busy),           32'd0);

      // draw that line: words 0x100+k, word 5 transparent
      ls(50, 100, 50, 1, 0, 0);
      pix_expect(99,  0, 16'h0000, "p99");
      pix_expect(100, 1, 16'h0100, "p100");
      pix_expect(104, 1, 16'h0104, "p104");
      pix_expect(105, 0, 16'h0000, "p105_key");
      pix_expect(106, 1, 16'h0106, "p106");
      pix_expect(131, 1, 16'h011F, "p131");
      pix_expect(132, 0, 16'h0000, "p132");
      for (int x = 95; x < 140; x++) pix_at(x, "sweep39");
      while (since < 34) tick();

      // abort: second line_start 10 cycles into a fetch
      ls(60, 100, 50, 0, 0, 0);
      repeat (10) tick();
      ls(61, 100, 50, 0, 0, 0);
      check("ovr_set",       32'(overrun),        32'd1);
      check("ovr_model",     32'(overrun),        32'(m_overrun));
      check("ovr_new_cs",    32'(mem_chipselect), 32'd1);
      check("ovr_new_addr",  32'(mem_address),    32'h180);
      pix_expect(100, 0, 16'h0000, "ovr_p100");
      for (int x = 96; x < 136; x++) pix_at(x, "ovr_sweep");
      overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
      check("ovr_clr", 32'(overrun), 32'd0);

      // clear and a fresh abort in the same cycle: set wins
      ls(70, 100, 50, 0, 0, 0);
      repeat (3) tick();
      ls(71, 100, 50, 0, 0, 1);
      check("ovr_setwins", 32'(overrun), 32'd1);
      overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
      check("ovr_clr2", 32'(overrun), 32'd0);
      while (since < 34) tick();

      // horizontal wrap at sprite_x=1020, then a line outside the sprite
      ls(10, 1020, 0, $urandom_range(0, 1), 0, 0);
      while (since < 34) tick();
      ls(200, 1020, 50, 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         check("nofetch_cs",   32'(mem_chipselect), 32'd0);
         check("nofetch_busy", 32'(busy),           32'd0);
         tick();
      end
      pix_expect(1019, 0, 16'h0000, "wrap_p1019");
      pix_expect(28,   0, 16'h0000, "wrap_p28");
      for (int x = 1010; x < 1070; x++) pix_at(x % 1024, "wrap_sweep");

      // vertical wrap: sprite_y near the top of the coordinate space
      ls(1022, 1000, 1020, 1, 0, 0);
      check_bus("vwrap");
      while (since < 34) tick();
      ls(1023, 1000, 1020, 1, 0, 0);
      for (int x = 995; x < 1040; x++) pix_at(x % 1024, "vwrap_sweep");
      while (since < 34) tick();

      // enable low: no fetch starts and no pixels
      enable = 1'b0;
      ls(49, 100, 50, 1, 0, 0);
      check_bus("dis");
      for (int x = 98; x < 110; x++) pix_at(x, "dis_pix");
      enable = 1'b1;

      // randomized lines, including occasional aborts
      for (int it = 0; it < 24; it++) begin
         int sx, sy, rs, n;
         sx = $urandom_range(0, 1023);
         sy = $urandom_range(0, 1023);
         rs = int'($urandom_range(0, 40)) - 4;
         ls(wrap(sy + rs - 1), sx, sy, $urandom_range(0, 1), $urandom_range(0, 1), 0);
         check("rnd_ovr", 32'(overrun), 32'(m_overrun));
         check_bus("rnd_ls");
         n = $urandom_range(10, 50);
         for (int j = 0; j < n; j++) begin
            pix_at(wrap(m_front_x + int'($urandom_range(0, 40)) - 4), "rnd_pix");
            check_bus("rnd");
         end
         if (it % 5 == 4) begin
            overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
            check("rnd_clr", 32'(overrun), 32'd0);
         end
      end
      while (since < 34) tick();

`ifdef SPRITE_MIRROR_EN
      // mirrored fetch: columns 31..0 descending
      ls(9, 300, 0, 0, 1, 0);
      for (int k = 0; k < 32; k++) begin
         check("mir_addr", 32'(mem_address), 32'(320 + 31 - k));
         tick();
      end
      tick();
      ls(10, 300, 0, 0, 0, 0);
      for (int x = 296; x < 336; x++) pix_at(x, "mir_pix");
      while (since < 34) tick();
`endif

      // reset in the middle of a fetch, with overrun previously set
      ls(49, 100, 50, 1, 0, 0);
      repeat (5) tick();
      ls(49, 100, 50, 1, 0, 0);
      repeat (5) tick();
      check("pre_rst_ovr", 32'(overrun), 32'd1);
      reset_n = 1'b0;
      #1;
      check("mrst_busy",  32'(busy),           32'd0);
      check("mrst_cs",    32'(mem_chipselect), 32'd0);
      check("mrst_addr",  32'(mem_address),    32'd0);
      check("mrst_ovr",   32'(overrun),        32'd0);
      check("mrst_valid", 32'(pix_valid),      32'd0);
      model_reset();
      tick();
      reset_n = 1'b1;
      tick();
      check_bus("post_rst");
      pix_at(100, "post_rst_pix");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
